// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding,
// default address base and the byte-address to SRAM halfword mapping.
package sram_mem_ctrl_pkg;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_WR_LO = 3'd3;
  localparam logic [2:0] ST_WR_HI = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD_LO = ST_RD_LO,
    RD_HI = ST_RD_HI,
    WR_LO = ST_WR_LO,
    WR_HI = ST_WR_HI,
    DONE  = ST_DONE
  } state_e;

  // Halfword base of the low half: ((addr - base) >> 2) << 1; callers truncate.
  function automatic logic [31:0] sram_addr_map(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
    logic [31:0] off;
    off = byte_addr - base;
    return {1'b0, off[31:2], 1'b0};
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one SRAM access phase; tc marks the last cycle.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic tc
);

  localparam int W = $clog2(WAIT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(WAIT_CYCLES - 1);
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] ZERO     = W'(0);

  logic [W-1:0] cnt_r;

  // Loading WAIT_CYCLES-1 makes the phase last exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (dec && !tc) begin
      cnt_r <= cnt_r - ONE;
    end
  end

  assign tc = (cnt_r == ZERO);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder: splits each 32-bit load/store into two timed 16-bit
// accesses on an asynchronous SRAM and holds ready low while busy.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_r_en,
  input  logic               MEM_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  state_e               state_r;
  state_e               next_s;
  logic [SRAM_AW-2:0]   word_r;
  logic [31:0]          wdata_r;
  logic [15:0]          lo_r;
  logic [31:0]          rdata_r;
  logic [31:0]          map_s;
  logic [SRAM_AW-2:0]   word_s;
  logic                 load_s;
  logic                 dec_s;
  logic                 tc_s;
  logic                 half_s;
  logic                 ready_s;
  logic                 ce_n_s;
  logic                 oe_n_s;
  logic                 we_n_s;
  logic                 dq_oe_s;
  logic [15:0]          dq_out_s;

  assign map_s  = sram_addr_map(addr, ADDR_BASE);
  assign word_s = (SRAM_AW-1)'(map_s >> 1);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst),
    .load (load_s),
    .dec  (dec_s),
    .tc   (tc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Request capture and load-data assembly; rdata only updates when a load completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_r  <= '0;
      wdata_r <= 32'h0000_0000;
      lo_r    <= 16'h0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      if (state_r == IDLE && load_s) begin
        word_r  <= word_s;
        wdata_r <= wdata;
      end
      if (state_r == RD_LO && tc_s) begin
        lo_r <= SRAM_DQ;
      end
      if (state_r == RD_HI && tc_s) begin
        rdata_r <= {SRAM_DQ, lo_r};
      end
    end
  end

  // Next-state, counter control and SRAM strobe decode.
  always_comb begin
    next_s   = state_r;
    load_s   = 1'b0;
    dec_s    = 1'b0;
    half_s   = 1'b0;
    ready_s  = 1'b0;
    ce_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    we_n_s   = 1'b1;
    dq_oe_s  = 1'b0;
    dq_out_s = 16'h0000;
    case (state_r)
      IDLE: begin
        ready_s = !(MEM_r_en || MEM_w_en);
        if (MEM_w_en) begin
          next_s = WR_LO;
          load_s = 1'b1;
        end else if (MEM_r_en) begin
          next_s = RD_LO;
          load_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      RD_LO: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
        dec_s  = 1'b1;
        if (tc_s) begin
          next_s = RD_HI;
          load_s = 1'b1;
        end else begin
          next_s = RD_LO;
        end
      end
      RD_HI: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
        dec_s  = 1'b1;
        half_s = 1'b1;
        if (tc_s) begin
          next_s = DONE;
        end else begin
          next_s = RD_HI;
        end
      end
      WR_LO: begin
        ce_n_s   = 1'b0;
        dec_s    = 1'b1;
        dq_oe_s  = 1'b1;
        dq_out_s = wdata_r[15:0];
        we_n_s   = tc_s;  // released on the last cycle so data is held past WE_N rise
        if (tc_s) begin
          next_s = WR_HI;
          load_s = 1'b1;
        end else begin
          next_s = WR_LO;
        end
      end
      WR_HI: begin
        ce_n_s   = 1'b0;
        dec_s    = 1'b1;
        half_s   = 1'b1;
        dq_oe_s  = 1'b1;
        dq_out_s = wdata_r[31:16];
        we_n_s   = tc_s;
        if (tc_s) begin
          next_s = DONE;
        end else begin
          next_s = WR_HI;
        end
      end
      DONE: begin
        ready_s = 1'b1;
        next_s  = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  assign SRAM_DQ   = dq_oe_s ? dq_out_s : 16'bz;
  assign SRAM_ADDR = {word_r, half_s};
  assign SRAM_CE_N = ce_n_s;
  assign SRAM_OE_N = oe_n_s;
  assign SRAM_WE_N = we_n_s;
  assign ready     = ready_s;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench: three controllers (WAIT_CYCLES 5, 2, 15) each on a
// behavioural SRAM, driven by a vector table, directed corner cases and random traffic.
module tb_sram_mem_ctrl;

  logic        clk;
  int          cyc;
  int          checks;
  int          failures;

  logic        rst_a    [3];
  logic        r_en_a   [3];
  logic        w_en_a   [3];
  logic [31:0] addr_a   [3];
  logic [31:0] wdata_a  [3];
  logic [31:0] rdata_a  [3];
  logic        ready_a  [3];
  logic [17:0] sa_a     [3];
  logic        ce_a     [3];
  logic        oe_a     [3];
  logic        we_a     [3];
  logic        probe_a  [3];
  logic [15:0] dqv_a    [3];

  // Reference model: 32-bit words keyed by instance and word index, plus last load result.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int WC = (gi == 0) ? 5 : ((gi == 1) ? 2 : 15);
    wire  [15:0] dq;
    logic [15:0] mem [0:262143];
    logic [17:0] lat_a;
    logic [15:0] lat_d;
    logic        lat_ce;

    sram_mem_ctrl #(
      .ADDR_BASE  (32'd1024),
      .SRAM_AW    (18),
      .WAIT_CYCLES(WC)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_a[gi]),
      .MEM_r_en (r_en_a[gi]),
      .MEM_w_en (w_en_a[gi]),
      .addr     (addr_a[gi]),
      .wdata    (wdata_a[gi]),
      .rdata    (rdata_a[gi]),
      .ready    (ready_a[gi]),
      .SRAM_DQ  (dq),
      .SRAM_ADDR(sa_a[gi]),
      .SRAM_CE_N(ce_a[gi]),
      .SRAM_OE_N(oe_a[gi]),
      .SRAM_WE_N(we_a[gi])
    );

    assign dq = (!ce_a[gi] && !oe_a[gi] && we_a[gi]) ? mem[sa_a[gi]] : 16'bz;
    assign dq = probe_a[gi] ? 16'h5A5A : 16'bz;
    assign dqv_a[gi] = dq;

    initial begin
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    end

    // Bus values sampled mid-cycle; an SRAM write commits them on the WE_N rising edge.
    always @(negedge clk) begin
      lat_a  <= sa_a[gi];
      lat_d  <= dq;
      lat_ce <= ce_a[gi];
    end

    always @(posedge we_a[gi]) begin
      if (!lat_ce) mem[lat_a] = lat_d;
    end
  end

  function automatic int wc_of(input int k);
    return (k == 0) ? 5 : ((k == 1) ? 2 : 15);
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    logic [31:0] w;
    w = ((a - 32'd1024) / 32'd4) % 32'd131072;
    return k * 32'h0010_0000 + int'(w);
  endfunction

  function automatic logic [31:0] ref_apply(input int k, input logic rd, input logic wr,
                                            input logic [31:0] a, input logic [31:0] d);
    if (wr) ref_mem[key(k, a)] = d;
    else if (rd) ref_rd[k] = ref_mem.exists(key(k, a)) ? ref_mem[key(k, a)] : 32'h0;
    return ref_rd[k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Presents one request in the cycle after the call and waits (bounded) for ready.
  task automatic do_req(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic scr, output int lat,
                        output int oec, output logic [31:0] rv, output int rcyc);
    lat = -1; oec = 0; rv = 32'h0; rcyc = -1;
    @(negedge clk);
    r_en_a[k] = rd; w_en_a[k] = wr; addr_a[k] = a; wdata_a[k] = d;
    #1;
    chk("ready_cycle0", {31'd0, ready_a[k]}, 32'd0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready_a[k]) begin
        lat = n; rv = rdata_a[k]; rcyc = cyc;
        break;
      end
      if (!oe_a[k]) oec++;
      if (scr && n == 2) begin
        addr_a[k] = $urandom; wdata_a[k] = $urandom;
      end
    end
    r_en_a[k] = 1'b0; w_en_a[k] = 1'b0;
  endtask

  task automatic txn(input int k, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input string nm);
    int lat, oec, rc;
    logic [31:0] rv, exp_r;
    exp_r = ref_apply(k, rd, wr, a, d);
    do_req(k, rd, wr, a, d, 1'b1, lat, oec, rv, rc);
    chk({nm, "_latency"}, lat, 2 * wc_of(k) + 1);
    chk({nm, "_oe_cycles"}, oec, (rd && !wr) ? 2 * wc_of(k) : 0);
    chk({nm, "_rdata"}, rv, exp_r);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vt [8];
    int   rc [8];
    int   lat, oec;
    logic [31:0] rv;
    int   op;

    checks = 0; failures = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b0; r_en_a[k] = 1'b0; w_en_a[k] = 1'b0;
      addr_a[k] = 32'h0; wdata_a[k] = 32'h0; probe_a[k] = 1'b0; ref_rd[k] = 32'h0;
    end

    vt[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 32'h0000_0000};
    vt[1] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 32'd1028,   32'h12345678, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF};
    vt[4] = '{1'b1, 1'b0, 32'd1028,   32'h0,        32'h12345678};
    vt[5] = '{1'b0, 1'b1, 32'd1020,   32'hCAFEF00D, 32'h12345678};
    vt[6] = '{1'b1, 1'b0, 32'd1022,   32'h0,        32'hCAFEF00D};
    vt[7] = '{1'b1, 1'b0, 32'd525312, 32'h0,        32'hDEADBEEF};

    // Reset values.
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'd0, ready_a[k]}, 32'd1);
      chk("rst_strobes", {29'd0, ce_a[k], oe_a[k], we_a[k]}, 32'd7);
      chk("rst_sram_addr", {14'd0, sa_a[k]}, 32'd0);
      chk("rst_rdata", rdata_a[k], 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b1;

    // Vector table on the default-timing instance; all requests back-to-back.
    for (int i = 0; i < 8; i++) begin
      void'(ref_apply(0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d));
      do_req(0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 1'b0, lat, oec, rv, rc[i]);
      chk("vec_latency", lat, 32'd11);
      chk("vec_oe_cycles", oec, (vt[i].rd && !vt[i].wr) ? 32'd10 : 32'd0);
      chk("vec_rdata", rv, vt[i].exp_rdata);
      if (i > 0) chk("vec_ready_spacing", rc[i] - rc[i-1], 32'd12);
    end
    chk("mem0", {16'd0, g_inst[0].mem[0]}, 32'h0000BEEF);
    chk("mem1", {16'd0, g_inst[0].mem[1]}, 32'h0000DEAD);
    chk("mem2", {16'd0, g_inst[0].mem[2]}, 32'h00005678);
    chk("mem3", {16'd0, g_inst[0].mem[3]}, 32'h00001234);
    chk("mem_wrap_lo", {16'd0, g_inst[0].mem[262142]}, 32'h0000F00D);
    chk("mem_wrap_hi", {16'd0, g_inst[0].mem[262143]}, 32'h0000CAFE);

    // Reset asserted in the middle of WR_HI.
    @(negedge clk);
    w_en_a[0] = 1'b1; addr_a[0] = 32'd1032; wdata_a[0] = 32'h1234ABCD;
    repeat (7) @(negedge clk);
    chk("abort_we_before", {31'd0, we_a[0]}, 32'd0);
    chk("abort_dq_before", {16'd0, dqv_a[0]}, 32'h00001234);
    rst_a[0] = 1'b0; probe_a[0] = 1'b1;
    #1;
    chk("abort_we", {31'd0, we_a[0]}, 32'd1);
    chk("abort_ce", {31'd0, ce_a[0]}, 32'd1);
    chk("abort_dq_released", {16'd0, dqv_a[0]}, 32'h00005A5A);
    chk("abort_ready_req", {31'd0, ready_a[0]}, 32'd0);
    w_en_a[0] = 1'b0;
    #1;
    chk("abort_ready_idle", {31'd0, ready_a[0]}, 32'd1);
    chk("abort_rdata", rdata_a[0], 32'd0);
    @(negedge clk);
    rst_a[0] = 1'b1; probe_a[0] = 1'b0; ref_rd[0] = 32'h0;
    ref_mem.delete(key(0, 32'd1032));
    txn(0, 1'b1, 1'b0, 32'd1024, 32'h0, "after_abort_load");

    // Same store/load pair on the short and long wait-state instances.
    for (int k = 1; k < 3; k++) begin
      txn(k, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "sweep_store");
      txn(k, 1'b1, 1'b0, 32'd1024, 32'h0, "sweep_load");
    end

    // Random traffic against the reference model; addr low bits and late input changes ignored.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ((k == 0) ? 30 : 15); i++) begin
        op = $urandom_range(0, 3);
        txn(k, (op != 2), (op >= 2),
            32'd1024 + 32'd4 * $urandom_range(16, 47) + $urandom_range(0, 3),
            $urandom, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
